// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the CPU datapath.
// The datapath supplies the opcode and ALU flags; the controller returns every strobe and select.
interface multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
   logic       sign;
   logic       PCWre;
   logic       IRWre;
   logic       RegWre;
   logic [1:0] RegDst;
   logic       WrRegDSrc;
   logic       ALUSrcA;
   logic       ALUSrcB;
   logic [2:0] ALUOp;
   logic       ExtSel;
   logic       mRD;
   logic       mWR;
   logic       DBDataSrc;
   logic [1:0] PCSrc;
   logic [3:0] state;

   modport master (
      input  opcode, zero, sign,
      output PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
             ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc, state
   );

   modport slave (
      output opcode, zero, sign,
      input  PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
             ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB per instruction class.
// Outputs decode combinationally from the current state and opcode; HALT parks until reset.
module multicycle_ctrl #(
   parameter logic [5:0] OP_HALT = 6'b111111
) (
   input  logic CLK,
   input  logic RST,
   multicycle_ctrl_if.master bus
);

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_WB_AL  = 4'd3,
      S_EXE_BR = 4'd4,
      S_EXE_LS = 4'd5,
      S_MEM    = 4'd6,
      S_WB_LD  = 4'd7,
      S_HALT   = 4'd8
   } state_e;

   state_e state_q, state_d;

   // Instruction class decode
   logic       is_alu, is_imm, is_ext, is_br, is_ls, is_lw, is_sw;
   logic       is_j, is_jr, is_jal, is_halt, taken;
   logic [2:0] alu_op_dec;

   always_comb begin
      is_alu     = 1'b0;
      is_imm     = 1'b0;
      is_ext     = 1'b0;
      alu_op_dec = 3'b000;
      case (bus.opcode)
         OP_ADD:   begin is_alu = 1'b1; alu_op_dec = 3'b000; end
         OP_SUB:   begin is_alu = 1'b1; alu_op_dec = 3'b001; end
         OP_ADDIU: begin is_alu = 1'b1; alu_op_dec = 3'b000; is_imm = 1'b1; is_ext = 1'b1; end
         OP_AND:   begin is_alu = 1'b1; alu_op_dec = 3'b100; end
         OP_ANDI:  begin is_alu = 1'b1; alu_op_dec = 3'b100; is_imm = 1'b1; end
         OP_ORI:   begin is_alu = 1'b1; alu_op_dec = 3'b101; is_imm = 1'b1; end
         OP_SLT:   begin is_alu = 1'b1; alu_op_dec = 3'b110; end
         OP_SLTI:  begin is_alu = 1'b1; alu_op_dec = 3'b110; is_imm = 1'b1; is_ext = 1'b1; end
         default:  ;
      endcase
   end

   assign is_lw   = (bus.opcode == OP_LW);
   assign is_sw   = (bus.opcode == OP_SW);
   assign is_ls   = is_lw | is_sw;
   assign is_br   = (bus.opcode == OP_BEQ) | (bus.opcode == OP_BNE) | (bus.opcode == OP_BLTZ);
   assign is_j    = (bus.opcode == OP_J);
   assign is_jr   = (bus.opcode == OP_JR);
   assign is_jal  = (bus.opcode == OP_JAL);
   assign is_halt = (bus.opcode == OP_HALT);

   assign taken = ((bus.opcode == OP_BEQ)  &  bus.zero) |
                  ((bus.opcode == OP_BNE)  & ~bus.zero) |
                  ((bus.opcode == OP_BLTZ) &  bus.sign);

   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF:     state_d = S_ID;
         S_ID: begin
            if (is_j || is_jr || is_jal) state_d = S_IF;
            else if (is_halt)            state_d = S_HALT;
            else if (is_br)              state_d = S_EXE_BR;
            else if (is_ls)              state_d = S_EXE_LS;
            else if (is_alu)             state_d = S_EXE_AL;
            else                         state_d = S_IF;
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
         S_WB_LD:  state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IF;
      else     state_q <= state_d;
   end

   logic       pc_wre, ir_wre, reg_wre, wr_reg_d_src, alu_src_a, alu_src_b;
   logic       ext_sel, m_rd, m_wr, db_data_src;
   logic [1:0] reg_dst, pc_src;
   logic [2:0] alu_op;

   always_comb begin
      pc_wre       = 1'b0;
      ir_wre       = 1'b0;
      reg_wre      = 1'b0;
      reg_dst      = 2'b00;
      wr_reg_d_src = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = 3'b000;
      ext_sel      = 1'b0;
      m_rd         = 1'b0;
      m_wr         = 1'b0;
      db_data_src  = 1'b0;
      pc_src       = 2'b00;
      case (state_q)
         S_IF: ir_wre = 1'b1;
         S_ID: begin
            if (is_j) begin
               pc_wre = 1'b1;
               pc_src = 2'b11;
            end else if (is_jr) begin
               pc_wre = 1'b1;
               pc_src = 2'b10;
            end else if (is_jal) begin
               // Link and jump share the cycle: PC+4 lands in $31 as PC moves.
               reg_wre      = 1'b1;
               reg_dst      = 2'b00;
               wr_reg_d_src = 1'b0;
               pc_wre       = 1'b1;
               pc_src       = 2'b11;
            end else if (!is_halt && !is_br && !is_ls && !is_alu) begin
               pc_wre = 1'b1;
            end
         end
         S_EXE_AL, S_WB_AL: begin
            alu_src_b = is_imm;
            ext_sel   = is_ext;
            alu_op    = alu_op_dec;
            if (state_q == S_WB_AL) begin
               reg_wre      = 1'b1;
               wr_reg_d_src = 1'b1;
               reg_dst      = is_imm ? 2'b01 : 2'b10;
               pc_wre       = 1'b1;
            end
         end
         S_EXE_BR: begin
            alu_op  = 3'b001;
            ext_sel = 1'b1;
            pc_wre  = 1'b1;
            pc_src  = taken ? 2'b01 : 2'b00;
         end
         S_EXE_LS, S_MEM: begin
            alu_src_b = 1'b1;
            ext_sel   = 1'b1;
            if (state_q == S_MEM) begin
               m_rd   = is_lw;
               m_wr   = is_sw;
               pc_wre = is_sw;
            end
         end
         S_WB_LD: begin
            m_rd         = 1'b1;
            db_data_src  = 1'b1;
            reg_wre      = 1'b1;
            reg_dst      = 2'b01;
            wr_reg_d_src = 1'b1;
            pc_wre       = 1'b1;
         end
         default: ;
      endcase
      if (RST) begin
         pc_wre  = 1'b0;
         ir_wre  = 1'b0;
         reg_wre = 1'b0;
         m_rd    = 1'b0;
         m_wr    = 1'b0;
      end
   end

   assign bus.PCWre     = pc_wre;
   assign bus.IRWre     = ir_wre;
   assign bus.RegWre    = reg_wre;
   assign bus.RegDst    = reg_dst;
   assign bus.WrRegDSrc = wr_reg_d_src;
   assign bus.ALUSrcA   = alu_src_a;
   assign bus.ALUSrcB   = alu_src_b;
   assign bus.ALUOp     = alu_op;
   assign bus.ExtSel    = ext_sel;
   assign bus.mRD       = m_rd;
   assign bus.mWR       = m_wr;
   assign bus.DBDataSrc = db_data_src;
   assign bus.PCSrc     = pc_src;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle lists from an instruction-level model.
module tb_multicycle_ctrl;

   localparam int C_ALU = 0, C_BR = 1, C_LS = 2, C_J = 3, C_JR = 4, C_JAL = 5, C_HALT = 6, C_UNDEF = 7;

   // Packed view of one cycle: state then every control output.
   typedef struct packed {
      logic [3:0] st;
      logic       pcwre;
      logic       irwre;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrsrc;
      logic       srca;
      logic       srcb;
      logic [2:0] aluop;
      logic       ext;
      logic       mrd;
      logic       mwr;
      logic       dbsrc;
      logic [1:0] pcsrc;
   } cyc_t;

   logic CLK, RST;
   multicycle_ctrl_if bus();

   multicycle_ctrl #(.OP_HALT(6'b111111)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   logic [20:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [20:0] observed();
      cyc_t c;
      c.st     = bus.state;
      c.pcwre  = bus.PCWre;
      c.irwre  = bus.IRWre;
      c.regwre = bus.RegWre;
      c.regdst = bus.RegDst;
      c.wrsrc  = bus.WrRegDSrc;
      c.srca   = bus.ALUSrcA;
      c.srcb   = bus.ALUSrcB;
      c.aluop  = bus.ALUOp;
      c.ext    = bus.ExtSel;
      c.mrd    = bus.mRD;
      c.mwr    = bus.mWR;
      c.dbsrc  = bus.DBDataSrc;
      c.pcsrc  = bus.PCSrc;
      return c;
   endfunction

   // ---------------- reference model ----------------
   task automatic describe(input logic [5:0] op, output int cls, output logic [2:0] aop,
                           output logic imm, output logic ext, output logic ld);
      cls = C_UNDEF; aop = 3'b000; imm = 1'b0; ext = 1'b0; ld = 1'b0;
      case (op)
         6'b000000: begin cls = C_ALU; aop = 3'b000; end
         6'b000001: begin cls = C_ALU; aop = 3'b001; end
         6'b000010: begin cls = C_ALU; aop = 3'b000; imm = 1'b1; ext = 1'b1; end
         6'b010000: begin cls = C_ALU; aop = 3'b100; end
         6'b010001: begin cls = C_ALU; aop = 3'b100; imm = 1'b1; end
         6'b010010: begin cls = C_ALU; aop = 3'b101; imm = 1'b1; end
         6'b100110: begin cls = C_ALU; aop = 3'b110; end
         6'b100111: begin cls = C_ALU; aop = 3'b110; imm = 1'b1; ext = 1'b1; end
         6'b110000: cls = C_LS;
         6'b110001: begin cls = C_LS; ld = 1'b1; end
         6'b110100, 6'b110101, 6'b110110: cls = C_BR;
         6'b111000: cls = C_J;
         6'b111001: cls = C_JR;
         6'b111010: cls = C_JAL;
         6'b111111: cls = C_HALT;
         default: ;
      endcase
   endtask

   task automatic build(input logic [5:0] op, input logic z, input logic s);
      int cls; logic [2:0] aop; logic imm, ext, ld, tk;
      cyc_t c;
      describe(op, cls, aop, imm, ext, ld);
      c = '0; c.st = 4'd0; c.irwre = 1'b1; exp_q.push_back(c);
      c = '0; c.st = 4'd1;
      case (cls)
         C_J:     begin c.pcwre = 1'b1; c.pcsrc = 2'b11; end
         C_JR:    begin c.pcwre = 1'b1; c.pcsrc = 2'b10; end
         C_JAL:   begin c.pcwre = 1'b1; c.pcsrc = 2'b11; c.regwre = 1'b1; c.regdst = 2'b00; end
         C_UNDEF: c.pcwre = 1'b1;
         default: ;
      endcase
      exp_q.push_back(c);
      if (cls == C_ALU) begin
         c = '0; c.st = 4'd2; c.srcb = imm; c.ext = ext; c.aluop = aop; exp_q.push_back(c);
         c.st = 4'd3; c.regwre = 1'b1; c.wrsrc = 1'b1; c.regdst = imm ? 2'b01 : 2'b10; c.pcwre = 1'b1;
         exp_q.push_back(c);
      end else if (cls == C_BR) begin
         tk = (op == 6'b110100) ? z : (op == 6'b110101) ? !z : s;
         c = '0; c.st = 4'd4; c.aluop = 3'b001; c.ext = 1'b1; c.pcwre = 1'b1; c.pcsrc = tk ? 2'b01 : 2'b00;
         exp_q.push_back(c);
      end else if (cls == C_LS) begin
         c = '0; c.st = 4'd5; c.srcb = 1'b1; c.ext = 1'b1; exp_q.push_back(c);
         c.st = 4'd6;
         if (ld) c.mrd = 1'b1;
         else begin c.mwr = 1'b1; c.pcwre = 1'b1; end
         exp_q.push_back(c);
         if (ld) begin
            c = '0; c.st = 4'd7; c.mrd = 1'b1; c.dbsrc = 1'b1; c.regwre = 1'b1; c.regdst = 2'b01;
            c.wrsrc = 1'b1; c.pcwre = 1'b1;
            exp_q.push_back(c);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_instr(input logic [5:0] op, input logic z, input logic s, input string tag);
      int pulses, idx;
      logic [20:0] e;
      exp_q.delete();
      build(op, z, s);
      bus.opcode = op; bus.zero = z; bus.sign = s;
      pulses = 0; idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge CLK);
         check_eq($sformatf("%s.c%0d", tag, idx), {11'b0, observed()}, {11'b0, e});
         check_eq($sformatf("%s.excl%0d", tag, idx), {31'b0, bus.mWR & bus.RegWre}, 32'd0);
         pulses += int'(bus.PCWre);
         idx++;
         @(posedge CLK); #1;
      end
      if (op != 6'b111111) check_eq({tag, ".pcw_pulses"}, pulses, 1);
   endtask

   task automatic reset_mid_sw();
      bus.opcode = 6'b110000; bus.zero = 1'b0; bus.sign = 1'b0;
      repeat (3) begin @(posedge CLK); #1; end
      @(negedge CLK);
      check_eq("rst.pre_state", {28'b0, bus.state}, 32'd6);
      RST = 1'b1;
      #1;
      check_eq("rst.mid_en", {27'b0, bus.PCWre, bus.mWR, bus.RegWre, bus.IRWre, bus.mRD}, 32'd0);
      @(posedge CLK); #1;
      @(negedge CLK);
      check_eq("rst.state1", {28'b0, bus.state}, 32'd0);
      check_eq("rst.en1", {27'b0, bus.PCWre, bus.mWR, bus.RegWre, bus.IRWre, bus.mRD}, 32'd0);
      @(posedge CLK); #1;
      check_eq("rst.state2", {28'b0, bus.state}, 32'd0);
      RST = 1'b0;
   endtask

   task automatic run_halt();
      cyc_t h;
      h = '0; h.st = 4'd8;
      run_instr(6'b111111, 1'b1, 1'b1, "halt");
      for (int i = 0; i < 20; i++) begin
         bus.zero = 1'($urandom_range(0, 1)); bus.sign = 1'($urandom_range(0, 1));
         @(negedge CLK);
         check_eq($sformatf("halt.park%0d", i), {11'b0, observed()}, {11'b0, h});
         @(posedge CLK); #1;
      end
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check_eq("halt.after_rst", {28'b0, bus.state}, 32'd0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      // ID reached with the halt opcode still applied would re-halt, so reset again cleanly.
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cls; logic [2:0] aop; logic imm, ext, ld;
      logic [5:0] op;
      RST = 1'b1; bus.opcode = 6'b0; bus.zero = 1'b0; bus.sign = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_eq("reset.state", {28'b0, bus.state}, 32'd0);
      check_eq("reset.en", {27'b0, bus.PCWre, bus.mWR, bus.RegWre, bus.IRWre, bus.mRD}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;

      run_instr(6'b000000, 1'b0, 1'b0, "add");
      run_instr(6'b110001, 1'b0, 1'b0, "lw");
      run_instr(6'b110000, 1'b0, 1'b0, "sw");
      run_instr(6'b110100, 1'b1, 1'b0, "beq_t");
      run_instr(6'b110100, 1'b0, 1'b0, "beq_n");
      run_instr(6'b110101, 1'b0, 1'b0, "bne_t");
      run_instr(6'b110101, 1'b1, 1'b1, "bne_n");
      run_instr(6'b110110, 1'b0, 1'b1, "bltz_t");
      run_instr(6'b110110, 1'b0, 1'b0, "bltz_n");
      run_instr(6'b111010, 1'b0, 1'b0, "jal");
      run_instr(6'b111001, 1'b0, 1'b0, "jr");
      run_instr(6'b111000, 1'b0, 1'b0, "j");
      run_instr(6'b101010, 1'b0, 1'b0, "undef");
      run_instr(6'b000010, 1'b0, 1'b0, "addiu");
      run_instr(6'b010010, 1'b0, 1'b0, "ori");
      reset_mid_sw();
      run_instr(6'b000001, 1'b0, 1'b0, "after_rst");
      run_halt();
      run_instr(6'b100111, 1'b0, 1'b0, "post_halt");

      for (int n = 0; n < 300; n++) begin
         op = 6'($urandom_range(0, 63));
         describe(op, cls, aop, imm, ext, ld);
         if (cls == C_HALT) op = 6'b100110;
         run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%b", n, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
